// File: rtl/gate_truth_table_checker_pkg.sv
// Shared types and constants for the gate truth-table checker:
// FSM state encoding, common truth tables and the sample-compare helper.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // Case inequality so an X/Z response from the gate never compares equal.
    function automatic logic is_mismatch(input logic y, input logic exp_bit);
        return (y !== exp_bit);
    endfunction

endpackage

// File: rtl/gate_truth_table_checker_settle_counter.sv
// Loadable down-counter that times how long each vector is held;
// zero_o flags the final settle cycle.
module settle_counter #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement, never decrement below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/gate_truth_table_checker.sv
// Exhaustive sequential tester for a small combinational gate: walks every
// input vector, samples the gate after a settle delay and scores it against EXPECT.
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter logic [(2**N_IN)-1:0]  EXPECT = TT_AND,
    parameter int                    SETTLE = 2,
    parameter int                    ERR_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             dut_y_i,
    output logic [N_IN-1:0]  vec_out_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [N_IN-1:0]  first_fail_vec_o,
    output logic             first_fail_vld_o
);

    localparam int               CW       = $clog2(SETTLE) + 1;
    localparam logic [CW-1:0]    CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = {N_IN{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_e            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              ffvld_q, ffvld_d;
    logic              cnt_load_s;
    logic              cnt_dec_s;
    logic              cnt_zero_s;
    logic              mismatch_s;

    settle_counter #(
        .W (CW)
    ) u_settle (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load_s),
        .dec_i      (cnt_dec_s),
        .load_val_i (CNT_LOAD),
        .zero_o     (cnt_zero_s)
    );

    // Next-state and result updates; idx doubles as the driven vector.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        ffv_d      = ffv_q;
        ffvld_d    = ffvld_q;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        mismatch_s = is_mismatch(dut_y_i, EXPECT[idx_q]);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d    = ST_SETTLE;
                    idx_d      = {N_IN{1'b0}};
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    err_d      = {ERR_W{1'b0}};
                    ffvld_d    = 1'b0;
                    cnt_load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch_s) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end else begin
                        err_d = err_q;
                    end
                    if (!ffvld_q) begin
                        ffv_d   = idx_q;
                        ffvld_d = 1'b1;
                    end else begin
                        ffv_d   = ffv_q;
                    end
                end else begin
                    err_d = err_q;
                end
                // pass looks at err_d so the final vector's verdict is included.
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == {ERR_W{1'b0}});
                end else begin
                    state_d    = ST_SETTLE;
                    idx_d      = idx_q + N_IN'(1);
                    cnt_load_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= {N_IN{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= {ERR_W{1'b0}};
            ffv_q   <= {N_IN{1'b0}};
            ffvld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvld_q <= ffvld_d;
        end
    end

    assign vec_out_o        = idx_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_count_o      = err_q;
    assign first_fail_vec_o = ffv_q;
    assign first_fail_vld_o = ffvld_q;

endmodule
